// File: rtl/accumulator_pkg.sv
// rtl/accumulator_pkg.sv - shared types and helpers for the frame accumulator
package accumulator_pkg;

    typedef enum logic {
        AccumSt = 1'b0,
        HoldSt  = 1'b1
    } accum_state_e;

    // Width of a counter that indexes 0..count-1, never narrower than one bit
    function automatic int unsigned calc_cnt_w(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - generic unsigned adder prim with carry out
module adder #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] in1_i,
    input  logic [Width-1:0] in2_i,
    output logic [Width-1:0] sum_o,
    output logic             carry_o
);

    // Full-width add; the extra top bit is the carry
    always_comb begin
        {carry_o, sum_o} = {1'b0, in1_i} + {1'b0, in2_i};
    end

endmodule

// File: rtl/accumulator.sv
// rtl/accumulator.sv - sums Count stream samples and presents the frame total
module accumulator
    import accumulator_pkg::*;
#(
    parameter int unsigned Width    = 8,
    parameter int unsigned Count    = 4,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] sum_o,
    output logic             overflow_o
);

    localparam int unsigned     CntW    = calc_cnt_w(Count);
    localparam logic [CntW-1:0] CntLast = CntW'(Count - 1);

    if (Count < 1) begin : gen_bad_count
        $error("accumulator: Count must be >= 1");
    end

    accum_state_e    state_q, state_d;
    logic [Width-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [Width-1:0] add_sum;
    logic             add_carry;

    adder #(
        .Width (Width)
    ) u_adder (
        .in1_i   (acc_q),
        .in2_i   (data_i),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // State registers; reset drops any partial or held frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= AccumSt;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: clear wins over any transfer in either state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            state_d = AccumSt;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                AccumSt: begin
                    if (valid_i) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_carry;
                        if (cnt_q == CntLast) begin
                            cnt_d   = '0;
                            state_d = HoldSt;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                HoldSt: begin
                    if (ready_i) begin
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = AccumSt;
                    end
                end
                default: begin
                    state_d = AccumSt;
                end
            endcase
        end
    end

    // Handshake and result outputs; ready is gated so a clearing cycle never takes a sample
    always_comb begin
        ready_o    = (state_q == AccumSt) && !clear_i;
        valid_o    = (state_q == HoldSt);
        sum_o      = (Saturate && ovf_q) ? {Width{1'b1}} : acc_q;
        overflow_o = ovf_q;
    end

endmodule
